// File: rtl/fifo_mem.sv
// Storage array for the FIFO: one write port and one registered read port.
// Memory contents are never reset; only the read-data register is.
module fifo_mem #(
   parameter int DATA_SIZE    = 8,
   parameter int ADDRESS_SIZE = 3,
   parameter int DEPTH        = 2 ** ADDRESS_SIZE
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic [ADDRESS_SIZE-1:0] wr_addr,
   input  logic [DATA_SIZE-1:0]    wr_data,
   input  logic                    rd_en,
   input  logic [ADDRESS_SIZE-1:0] rd_addr,
   output logic [DATA_SIZE-1:0]    rd_data
);

   logic [DATA_SIZE-1:0] mem_q [DEPTH];
   logic [DATA_SIZE-1:0] rd_data_d, rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_addr] <= wr_data;
   end

   // Read data holds its last value unless a read is accepted.
   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) rd_data_d = mem_q[rd_addr];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rd_data_q <= '0;
      else      rd_data_q <= rd_data_d;
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo.sv
// Single-clock synchronous FIFO: extra-MSB pointers for full/empty,
// registered read data and sticky overflow/underflow flags.
module fifo #(
   parameter int DATA_SIZE    = 8,
   parameter int ADDRESS_SIZE = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic                 pop,
   input  logic [DATA_SIZE-1:0] data_in,
   output logic [DATA_SIZE-1:0] data_out,
   output logic                 full,
   output logic                 empty,
   output logic                 overflow,
   output logic                 underflow
);

   localparam int DEPTH = 2 ** ADDRESS_SIZE;

   logic [ADDRESS_SIZE:0] wr_ptr_d, wr_ptr_q;
   logic [ADDRESS_SIZE:0] rd_ptr_d, rd_ptr_q;
   logic                  overflow_d, overflow_q;
   logic                  underflow_d, underflow_q;
   logic                  wr_en, rd_en;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[ADDRESS_SIZE-1:0] == rd_ptr_q[ADDRESS_SIZE-1:0]) &&
                  (wr_ptr_q[ADDRESS_SIZE] != rd_ptr_q[ADDRESS_SIZE]);

   // A pop on the same edge frees the slot, so a full FIFO still takes the push.
   assign wr_en = push & (~full | pop);
   assign rd_en = pop & ~empty;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && full && !pop) overflow_d = 1'b1;
      else if (rd_en)           overflow_d = 1'b0;
      // Push+pop on empty sets underflow even though the push is accepted.
      if (pop && empty)         underflow_d = 1'b1;
      else if (wr_en)           underflow_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;

   fifo_mem #(
      .DATA_SIZE    (DATA_SIZE),
      .ADDRESS_SIZE (ADDRESS_SIZE),
      .DEPTH        (DEPTH)
   ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr_q[ADDRESS_SIZE-1:0]),
      .wr_data (data_in),
      .rd_en   (rd_en),
      .rd_addr (rd_ptr_q[ADDRESS_SIZE-1:0]),
      .rd_data (data_out)
   );

endmodule

// File: tb/tb_fifo.sv
// Directed bench for fifo: a reference queue model predicts acceptance and
// flags; popped words go to a scoreboard and are compared when data_out updates.
module tb_fifo;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       push = 1'b0;
   logic       pop = 1'b0;
   logic [7:0] data_in = '0;
   logic [7:0] data_out;
   logic       full, empty, overflow, underflow;

   int tests = 0;
   int fails = 0;

   logic [7:0] model[$];
   logic [7:0] sb[$];
   logic [7:0] m_dout = '0;
   logic       m_ovf = 1'b0;
   logic       m_udf = 1'b0;

   fifo #(.DATA_SIZE(8), .ADDRESS_SIZE(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .data_in   (data_in),
      .data_out  (data_out),
      .full      (full),
      .empty     (empty),
      .overflow  (overflow),
      .underflow (underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_flags(input string tag);
      chk({tag, ".empty"},     {31'd0, empty},     {31'd0, model.size() == 0});
      chk({tag, ".full"},      {31'd0, full},      {31'd0, model.size() == 8});
      chk({tag, ".overflow"},  {31'd0, overflow},  {31'd0, m_ovf});
      chk({tag, ".underflow"}, {31'd0, underflow}, {31'd0, m_udf});
      chk({tag, ".dout"},      {24'd0, data_out},  {24'd0, m_dout});
   endtask

   task automatic step(input string tag, input logic p, input logic q, input logic [7:0] d);
      logic mfull, mempty, wr, rd;
      logic [7:0] e;
      @(negedge clk);
      push = p; pop = q; data_in = d;
      mfull  = (model.size() == 8);
      mempty = (model.size() == 0);
      wr = p && (!mfull || q);
      rd = q && !mempty;
      if (rd) sb.push_back(model.pop_front());
      if (wr) model.push_back(d);
      if (p && mfull && !q) m_ovf = 1'b1;
      else if (rd)          m_ovf = 1'b0;
      if (q && mempty)      m_udf = 1'b1;
      else if (wr)          m_udf = 1'b0;
      @(posedge clk);
      #1;
      if (rd) begin
         e = sb.pop_front();
         m_dout = e;
         chk({tag, ".sb"}, {24'd0, data_out}, {24'd0, e});
      end
      chk_flags(tag);
   endtask

   task automatic model_reset();
      model.delete();
      sb.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
   endtask

   initial begin
      // Reset
      #12;
      chk_flags("reset");
      @(negedge clk);
      rst = 1'b1;

      // Fill then drain in order
      for (int i = 0; i < 8; i++) step("fill", 1'b1, 1'b0, 8'(i));
      for (int i = 0; i < 8; i++) step("drain", 1'b0, 1'b1, 8'h00);

      // Streaming with one entry resident
      step("stream_pre", 1'b1, 1'b0, 8'h00);
      for (int i = 1; i <= 8; i++) step("stream", 1'b1, 1'b1, 8'(i));
      step("stream_post", 1'b0, 1'b1, 8'h00);

      // Overflow: ninth push dropped, first pop clears flag
      for (int i = 0; i < 8; i++) step("ovf_fill", 1'b1, 1'b0, 8'(i));
      step("ovf_push", 1'b1, 1'b0, 8'hAA);
      step("ovf_push2", 1'b1, 1'b0, 8'hBB);
      for (int i = 0; i < 8; i++) step("ovf_drain", 1'b0, 1'b1, 8'h00);

      // Underflow from empty; push clears it
      for (int i = 0; i < 5; i++) step("udf_pop", 1'b0, 1'b1, 8'h00);
      step("udf_push", 1'b1, 1'b0, 8'h55);
      step("udf_read", 1'b0, 1'b1, 8'h00);

      // Push+pop while empty: push taken, pop rejected, underflow set
      step("empty_pp", 1'b1, 1'b1, 8'h66);
      step("empty_pp_rd", 1'b0, 1'b1, 8'h00);

      // Push+pop while full: both accepted, no overflow
      for (int i = 0; i < 8; i++) step("full_fill", 1'b1, 1'b0, 8'(8'h10 + i));
      step("full_pp", 1'b1, 1'b1, 8'h77);
      for (int i = 0; i < 3; i++) step("full_rd", 1'b0, 1'b1, 8'h00);

      // Asynchronous reset mid-fill
      @(negedge clk);
      push = 1'b0; pop = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      chk_flags("async_rst");
      @(negedge clk);
      rst = 1'b1;
      step("post_rst_push", 1'b1, 1'b0, 8'h99);
      step("post_rst_pop", 1'b0, 1'b1, 8'h00);
      step("post_rst_empty", 1'b0, 1'b1, 8'h00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fifo.md
Name: fifo

Overview:
- Single-clock synchronous FIFO with parameterised data width and power-of-two depth.
- Registered read data, full/empty status, and sticky overflow/underflow error flags.
- Used as a generic buffer between a producer issuing push and a consumer issuing pop in the same clock domain.

Parameters:
- DATA_SIZE, 8: width of each stored word in bits.
- ADDRESS_SIZE, 3: pointer width; depth = 2**ADDRESS_SIZE (default 8 entries).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset.
- push  in  1  write request; data_in is captured on the rising edge when the write is accepted.
- pop  in  1  read request.
- data_in  in  DATA_SIZE  write data.
- data_out  out  DATA_SIZE  registered read data.
- full  out  1  high when the FIFO holds depth entries.
- empty  out  1  high when the FIFO holds 0 entries.
- overflow  out  1  sticky error flag: a push was rejected.
- underflow  out  1  sticky error flag: a pop was rejected.

Behaviour:
- Reset (rst=0, asynchronous): write and read pointers = 0, count = 0, data_out = 0, empty = 1, full = 0, overflow = 0, underflow = 0. Memory contents are not cleared.
- Reset mid-operation discards all stored entries immediately. The first edge after release behaves as an empty FIFO.
- Pointers are ADDRESS_SIZE+1 bits wide, so wrap-around is natural.
  - empty = (wr_ptr == rd_ptr).
  - full = (low bits equal AND MSBs differ).
  - Both flags are combinational from the registered pointers, so they are valid in the cycle after the causing edge.
- Write accept: wr_en = push & (!full | pop). On wr_en, mem[wr_ptr] <= data_in and wr_ptr increments.
- Read accept: rd_en = pop & !empty. On rd_en, data_out <= mem[rd_ptr] and rd_ptr increments. Latency: data is valid after the edge that accepts the pop.
- data_out holds its last value when no pop is accepted.
- Simultaneous push and pop:
  - Not empty: both are accepted; occupancy is unchanged.
  - Full: both are accepted; no overflow.
  - Empty: push is accepted, pop is rejected. There is no bypass, and underflow is set.
- Overflow:
  - Set on an edge where push=1 and full=1 and pop=0; that write is dropped and memory is unchanged.
  - Cleared on reset or on any accepted pop.
- Underflow:
  - Set on an edge where pop=1 and empty=1; data_out is unchanged.
  - Cleared on reset or on any accepted push.
- Rejected operations never move a pointer.

Decomposition:
- No shared package is needed.
- DEPTH is a localparam (2**ADDRESS_SIZE) inside the module.
- A single module is sufficient. The storage array may optionally be split into a sub-module fifo_mem (write port plus registered read port), with pointer/flag logic kept in fifo.

Test Plan:
- Reset: drive rst=0 then 1 -> empty=1, full=0, overflow=0, underflow=0, data_out=0.
- Fill: push data_in=0..7 on 8 consecutive edges -> full=1, empty=0, overflow=0.
- Drain in order: pop on 8 consecutive edges -> after the k-th pop edge data_out=k-1 (0..7); then empty=1, full=0, underflow=0.
- Streaming: with 1 entry stored (value 0), hold push=pop=1 with data_in=1..8 for 8 edges -> data_out sequence 0,1,...,7; occupancy stays 1; no flags set.
- Overflow: fill 8 entries, then push data_in=0xAA one more edge -> overflow=1, full=1. Drain yields 0..7; 0xAA is never output. The first accepted pop clears overflow.
- Underflow and reset: from empty, pop for 5 edges -> underflow=1, data_out unchanged, pointers unchanged. A following push clears underflow. Asserting rst mid-fill returns empty=1 asynchronously.
